// File: rtl/alu8_pkg.sv
// Shared definitions for the alu8_arbiter slice: opcodes, FSM state encoding
// and the default operand width.
package alu8_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu8_core.sv
// Combinational ALU: ADD with carry-out, bitwise AND/OR/XOR with carry forced low.
module alu8_core
    import alu8_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    logic [DATA_W:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: {carry, y} = w_sum;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            default: begin
                y     = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu8_arbiter.sv
// Two-requester ALU with a one-entry result register and round-robin grant.
// Define ALU8_ARBITER_FIXED_PRIO_EN to make requester 0 always win ties.
module alu8_arbiter
    import alu8_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req0_op,
    input  logic [1:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_carry
);

    state_e            r_state;
    logic [DATA_W-1:0] r_y;
    logic              r_carry;
    logic              r_id;

    logic              w_slot_free;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [1:0]        w_op;
    logic [DATA_W-1:0] w_y;
    logic              w_carry;

`ifdef ALU8_ARBITER_FIXED_PRIO_EN
    assign w_gnt1 = req1_valid & ~req0_valid;
`else
    logic r_last_id;

    // On a tie, requester 1 wins only if requester 0 was granted last.
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_id);
`endif

    assign w_gnt0 = req0_valid & ~w_gnt1;

    // Slot frees when empty or when the held result drains this same cycle.
    assign w_slot_free = rst_n & ((r_state == ST_EMPTY) | rsp_ready);
    assign req0_ready  = w_gnt0 & w_slot_free;
    assign req1_ready  = w_gnt1 & w_slot_free;
    assign w_accept    = req0_ready | req1_ready;

    assign w_a  = w_gnt1 ? req1_a  : req0_a;
    assign w_b  = w_gnt1 ? req1_b  : req0_b;
    assign w_op = w_gnt1 ? req1_op : req0_op;

    alu8_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .a     (w_a),
        .b     (w_b),
        .op    (w_op),
        .y     (w_y),
        .carry (w_carry)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_y       <= '0;
            r_carry   <= 1'b0;
            r_id      <= 1'b0;
`ifdef ALU8_ARBITER_FIXED_PRIO_EN
`else
            r_last_id <= 1'b1;
`endif
        end else begin
            if (w_accept) begin
                r_state   <= ST_FULL;
                r_y       <= w_y;
                r_carry   <= w_carry;
                r_id      <= w_gnt1;
`ifdef ALU8_ARBITER_FIXED_PRIO_EN
`else
                r_last_id <= w_gnt1;
`endif
            end else if (r_state == ST_FULL && rsp_ready) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_y     = r_y;
    assign rsp_carry = r_carry;
    assign rsp_id    = r_id;

endmodule

// File: doc/alu8_arbiter.md
ALU8_ARBITER -- requirements
Module: alu8_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width; only 8 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  request pending.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DATA_W  operands.
REQ-007 SHALL have ports req0_op/req1_op  input  2  opcode: 00 ADD, 01 AND, 10 OR, 11 XOR.
REQ-008 SHALL have port rsp_valid  output  1  result held.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port rsp_id  output  1  requester index of held result.
REQ-011 SHALL have port rsp_y  output  DATA_W  result.
REQ-012 SHALL have port rsp_carry  output  1  ADD carry-out; 0 for logic ops.

Function
REQ-013 SHALL implement a two-state FSM: EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-014 SHALL accept a request (raise exactly one reqN_ready) when in EMPTY, or in FULL while rsp_ready=1 (same-cycle drain and refill).
REQ-015 SHALL never assert both req0_ready and req1_ready in one cycle; ready is combinational from valids, state and pointer.
REQ-016 SHALL register the accepted request's ALU result, carry and index at the accept edge; rsp_valid rises the next cycle (latency 1).
REQ-017 SHALL compute ADD as 9-bit sum {carry, y} = a + b, wrapping modulo 256; AND/OR/XOR bitwise, carry 0.
REQ-018 SHALL, with one requester valid, grant it regardless of pointer.
REQ-019 SHALL, with both valid, grant the requester not granted last (round-robin pointer last_id, updated on every grant).
REQ-020 SHALL hold rsp_y, rsp_carry, rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL go FULL->EMPTY when rsp_ready=1 and no request is accepted that cycle.
REQ-022 SHALL tolerate reqN_valid dropping without acceptance (no request is latched).

Reset
REQ-023 SHALL, on rst_n=0 at any time, go EMPTY immediately: rsp_valid=0, rsp_y=0, rsp_carry=0, rsp_id=0, last_id=1 (requester 0 wins first tie).
REQ-024 SHALL discard any held result on reset mid-operation; readies deassert while rst_n=0.

Configuration
REQ-025 SHALL, with macro ALU8_ARBITER_FIXED_PRIO_EN defined, grant requester 0 whenever both are valid and omit the last_id register.
REQ-026 SHALL, without ALU8_ARBITER_FIXED_PRIO_EN, use the round-robin rule of REQ-019.

Structure
REQ-027 SHALL take opcode constants (OP_ADD, OP_AND, OP_OR, OP_XOR), the state encoding and DATA_W default from shared package alu8_pkg.
REQ-028 SHALL place the combinational ALU in sub-module alu8_core (a, b, op -> y, carry), instantiated once.

Verification
REQ-029 SHALL cover: reset, req0 ADD a=0x0F b=0x01 -> req0_ready=1, next cycle rsp_valid=1, rsp_y=0x10, rsp_carry=0, rsp_id=0.
REQ-030 SHALL cover: req1 ADD 0xFF+0x02 -> rsp_y=0x01, rsp_carry=1, rsp_id=1.
REQ-031 SHALL cover: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 (round-robin) or 0,0,0,0 (FIXED_PRIO_EN).
REQ-032 SHALL cover: FULL with rsp_ready=0 for 5 cycles, req0 XOR 0xAA^0x55 pending -> no ready, rsp outputs stable; rsp_ready=1 -> same-cycle accept, next rsp_y=0xFF.
REQ-033 SHALL cover: rst_n low while FULL -> rsp_valid=0 asynchronously; after release first tie grants requester 0.
